// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_stage
// Brief    : PC register, async-read imem address, and {pc,instr} FIFO to decode.
//            Optional perf counters are enabled by defining FETCH_QUEUE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     INCR     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_base,
  input  logic [XLEN-1:0]          redirect_disp,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [XLEN-1:0]          imem_rdata,
  input  logic                     dec_ready,
  output logic                     dec_valid,
  output logic [XLEN-1:0]          dec_instr,
  output logic [XLEN-1:0]          dec_pc,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]              perf_fetched,
  output logic [31:0]              perf_flushed,
`endif
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int unsigned     PW      = $clog2(QDEPTH);
  localparam int unsigned     CW      = PW + 1;
  localparam logic [CW-1:0]   C_DEPTH = CW'(QDEPTH);
  localparam logic [XLEN-1:0] C_INCR  = XLEN'(INCR);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] pc_mem_q    [QDEPTH];
  logic [XLEN-1:0] instr_mem_q [QDEPTH];

  logic            w_pop;
  logic            w_push;
  logic [XLEN-1:0] w_target;

  assign w_target  = redirect_base + redirect_disp;
  assign dec_valid = (count_q != '0) & ~redirect;
  assign w_pop     = dec_valid & dec_ready;
  // A pop frees the slot the push lands in, so a full queue still accepts a fetch.
  assign w_push    = ~redirect & ((count_q < C_DEPTH) | w_pop);

  assign imem_addr = pc_q;
  assign q_count   = count_q;
  assign dec_pc    = dec_valid ? pc_mem_q[head_q]    : '0;
  assign dec_instr = dec_valid ? instr_mem_q[head_q] : '0;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = w_target;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) begin
        pc_d   = pc_q + C_INCR;
        tail_d = tail_q + PW'(1);
      end
      if (w_pop) begin
        head_d = head_q + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      pc_mem_q[tail_q]    <= pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_flushed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
    end else begin
      if (w_push) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (redirect) begin
        perf_flushed_q <= perf_flushed_q + 32'(count_q);
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue_stage
// Brief    : Scoreboard bench for fetch_queue_stage: directed phases then random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_stage;

  localparam int          XLEN   = 32;
  localparam int          QDEPTH = 4;
  localparam logic [31:0] RPC    = 32'h0000_0100;
  localparam logic [31:0] PAT    = 32'hA5A5_A5A5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, redirect, dec_ready;
  logic [31:0] redirect_base, redirect_disp;
  logic [31:0] imem_addr, imem_rdata;
  logic        dec_valid;
  logic [31:0] dec_instr, dec_pc;
  logic [2:0]  q_count;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched, perf_flushed;
  logic [31:0] m_fetched, m_flushed;
`endif

  always #5 clk = ~clk;

  // Instruction memory: content is a fixed function of the address.
  assign imem_rdata = imem_addr ^ PAT;

  fetch_queue_stage #(
    .XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC(RPC), .INCR(4)
  ) dut (
    .clk(clk), .rst(rst), .redirect(redirect),
    .redirect_base(redirect_base), .redirect_disp(redirect_disp),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .dec_ready(dec_ready), .dec_valid(dec_valid),
    .dec_instr(dec_instr), .dec_pc(dec_pc),
`ifdef FETCH_QUEUE_PERF_EN
    .perf_fetched(perf_fetched), .perf_flushed(perf_flushed),
`endif
    .q_count(q_count)
  );

  ent_t        exp_q[$];
  logic [31:0] model_pc;
  bit          started = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares what the DUT presents against the scoreboard queue.
  always @(negedge clk) begin
    bit ev;
    #2;
    if (started) begin
      ev = (exp_q.size() != 0) && !redirect;
      check("dec_valid", 32'(dec_valid), 32'(ev));
      check("q_count", 32'(q_count), 32'(exp_q.size()));
      check("imem_addr", imem_addr, model_pc);
`ifdef FETCH_QUEUE_PERF_EN
      check("perf_fetched", perf_fetched, m_fetched);
      check("perf_flushed", perf_flushed, m_flushed);
`endif
      if (ev) begin
        check("dec_pc", dec_pc, exp_q[0].pc);
        check("dec_instr", dec_instr, exp_q[0].instr);
        if (dec_ready) exp_q.delete(0);
      end else begin
        check("dec_pc_idle", dec_pc, 32'h0);
        check("dec_instr_idle", dec_instr, 32'h0);
      end
    end
  end

  // One clock of stimulus; the reference model advances at the edge.
  task automatic cyc(input bit r, input bit rd, input logic [31:0] b,
                     input logic [31:0] d, input bit rdy);
    ent_t e;
    @(negedge clk);
    rst = r; redirect = rd; redirect_base = b; redirect_disp = d; dec_ready = rdy;
    @(posedge clk);
    if (r) begin
      model_pc = RPC;
      exp_q.delete();
`ifdef FETCH_QUEUE_PERF_EN
      m_fetched = 0; m_flushed = 0;
`endif
    end else if (rd) begin
`ifdef FETCH_QUEUE_PERF_EN
      m_flushed += 32'(exp_q.size());
`endif
      exp_q.delete();
      model_pc = b + d;
    end else if (exp_q.size() < QDEPTH) begin
      e.pc = model_pc;
      e.instr = model_pc ^ PAT;
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
`ifdef FETCH_QUEUE_PERF_EN
      m_fetched += 1;
`endif
    end
    started = 1'b1;
  endtask

  initial begin
    logic [31:0] b, d;
    rst = 1'b1; redirect = 1'b0; redirect_base = '0; redirect_disp = '0; dec_ready = 1'b0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1);
    repeat (8)  cyc(0, 0, 0, 0, 1);
    repeat (10) cyc(0, 0, 0, 0, 0);
    repeat (8)  cyc(0, 0, 0, 0, 1);
    // Build three entries, then redirect over them.
    cyc(0, 1, 32'h0000_3000, 32'h0, 0);
    repeat (3)  cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0000_2000, 32'hFFFF_FFF0, 1);
    repeat (6)  cyc(0, 0, 0, 0, 1);
    // Address wrap across 2^32.
    cyc(0, 1, 32'hFFFF_FFF0, 32'h0000_0008, 1);
    repeat (6)  cyc(0, 0, 0, 0, 1);
    // Full queue, then reset together with a redirect.
    repeat (6)  cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 32'h0000_4000, 32'h4, 1);
    repeat (3)  cyc(0, 0, 0, 0, 1);
    // Full queue streaming push/pop, then redirect flushing four entries.
    repeat (6)  cyc(0, 0, 0, 0, 0);
    repeat (8)  cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 32'h0000_5000, 32'h0, 0);
    repeat (4)  cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      b = $urandom;
      d = ($urandom_range(0, 3) == 0) ? 32'(-$urandom_range(0, 64)) : $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFE0;
      cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0), b, d,
          ($urandom_range(0, 9) < 7));
    end
    @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
